// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: opcodes, phase state encodings
// and the strobe bundle that the decoder produces.
// Pure types and constants; no logic.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_S0     = 4'd1,
    ST_S1     = 4'd2,
    ST_S2     = 4'd3,
    ST_S3     = 4'd4,
    ST_S4     = 4'd5,
    ST_S5     = 4'd6,
    ST_S6     = 4'd7,
    ST_S7     = 4'd8,
    ST_HALTED = 4'd9
  } state_t;

  // The seven bus/register strobes driven per phase.
  typedef struct packed {
    logic load_ir;
    logic rd;
    logic wr;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic datactl_ena;
  } strobe_t;

endpackage

// File: rtl/machine_ctrl_decode.sv
// Phase output decode: maps the state about to be entered (plus opcode and
// zero flag) to the strobes and halt flag that will be registered with it.
// Purely combinational; the caller registers the result alongside the state.
module machine_ctrl_decode
  import cpu_pkg::*;
(
  input  state_t     nxt_state,
  input  logic [2:0] opc,
  input  logic       zero,
  output strobe_t    strb,
  output logic       halt
);

  // Strobes for the phase being entered; everything defaults to idle.
  always_comb begin
    strb = '0;
    halt = 1'b0;
    case (nxt_state)
      ST_S0, ST_S1: begin
        // Two consecutive fetches: hi byte then lo byte.
        strb.rd      = 1'b1;
        strb.load_ir = 1'b1;
        strb.inc_pc  = 1'b1;
      end
      ST_S3: begin
        halt = (opc == OP_HLT);
      end
      ST_S4: begin
        case (opc)
          OP_ADD, OP_AND, OP_XOR, OP_LDA: strb.rd          = 1'b1;
          OP_STO:                         strb.datactl_ena = 1'b1;
          OP_JMP:                         strb.load_pc     = 1'b1;
          default: ;
        endcase
      end
      ST_S5: begin
        case (opc)
          OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
            strb.rd       = 1'b1;
            strb.load_acc = 1'b1;
          end
          OP_STO: begin
            strb.datactl_ena = 1'b1;
            strb.wr          = 1'b1;
          end
          OP_JMP: strb.load_pc = 1'b1;
          OP_SKZ: strb.inc_pc  = zero;
          default: ;
        endcase
      end
      ST_S6: begin
        // Second PC increment of a taken SKZ skips a whole 2-byte instruction.
        case (opc)
          OP_STO: strb.datactl_ena = 1'b1;
          OP_SKZ: strb.inc_pc      = zero;
          default: ;
        endcase
      end
      ST_HALTED: begin
        halt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/machine_ctrl.sv
// CPU main sequencer: fixed 8-phase cycle per instruction with registered strobes.
// Outputs change on the edge that enters a phase and hold for that one cycle.
// ENA low abandons the current instruction and returns to IDLE on the next edge.
module machine_ctrl
  import cpu_pkg::*;
#(
  parameter int OPC_W       = 3,
  parameter int CNT_W       = 16,
  parameter int HALT_STICKY = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENA,
  input  logic [OPC_W-1:0] OPCODE,
  input  logic             ZERO,
  output logic             LOAD_IR,
  output logic             RD,
  output logic             WR,
  output logic             INC_PC,
  output logic             LOAD_PC,
  output logic             LOAD_ACC,
  output logic             DATACTL_ENA,
  output logic             HALT,
  output logic [CNT_W-1:0] INSTR_CNT
);

  state_t           state;
  state_t           state_nxt;
  strobe_t          strb_d;
  strobe_t          strb_q;
  logic             halt_d;
  logic             halt_q;
  logic [2:0]       opc;
  logic [CNT_W-1:0] cnt;

  assign opc = OPCODE[2:0];

  // Next-phase selection; any unknown encoding falls back to IDLE.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = ENA ? ST_S0 : ST_IDLE;
      ST_S0:   state_nxt = ENA ? ST_S1 : ST_IDLE;
      ST_S1:   state_nxt = ENA ? ST_S2 : ST_IDLE;
      ST_S2:   state_nxt = ENA ? ST_S3 : ST_IDLE;
      ST_S3: begin
        if (!ENA)
          state_nxt = ST_IDLE;
        else if ((HALT_STICKY != 0) && (opc == OP_HLT))
          state_nxt = ST_HALTED;
        else
          state_nxt = ST_S4;
      end
      ST_S4:     state_nxt = ENA ? ST_S5 : ST_IDLE;
      ST_S5:     state_nxt = ENA ? ST_S6 : ST_IDLE;
      ST_S6:     state_nxt = ENA ? ST_S7 : ST_IDLE;
      ST_S7:     state_nxt = ENA ? ST_S0 : ST_IDLE;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  machine_ctrl_decode u_decode (
    .nxt_state (state_nxt),
    .opc       (opc),
    .zero      (ZERO),
    .strb      (strb_d),
    .halt      (halt_d)
  );

  // State, strobes and retired count advance together on each edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      strb_q <= '0;
      halt_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      strb_q <= strb_d;
      halt_q <= halt_d;
      // Only a completed S7 -> S0 wrap retires an instruction.
      if ((state == ST_S7) && (state_nxt == ST_S0))
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign LOAD_IR     = strb_q.load_ir;
  assign RD          = strb_q.rd;
  assign WR          = strb_q.wr;
  assign INC_PC      = strb_q.inc_pc;
  assign LOAD_PC     = strb_q.load_pc;
  assign LOAD_ACC    = strb_q.load_acc;
  assign DATACTL_ENA = strb_q.datactl_ena;
  assign HALT        = halt_q;
  assign INSTR_CNT   = cnt;

endmodule
